// File: rtl/dac_spi_tx.sv
// dac_spi_tx: scale-and-saturate an 18-bit 1.3.14 sample to a 12-bit
// offset-binary DAC code and send it as one {CMD, code} SPI frame (mode 0).
// Optional build macro DAC_SAT_COUNT_EN adds o_sat_cnt, a 16-bit saturating
// count of o_sat pulses.
//
// state | meaning
// IDLE  | ready for a sample, bus idle
// XFER  | shifting the frame out, CS_N low
// GAP   | CS_N high recovery time before the next frame
module dac_spi_tx #(
  parameter int         IN_W     = 18,
  parameter int         OUT_W    = 12,
  parameter int         SHIFT    = 5,
  parameter logic [3:0] CMD      = 4'b0011,
  parameter int         SCLK_DIV = 2,
  parameter int         CS_GAP   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [IN_W-1:0] i_sample,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic                   o_sat,
  output logic                   o_cs_n,
  output logic                   o_sclk,
  output logic                   o_mosi
`ifdef DAC_SAT_COUNT_EN
  ,
  output logic [15:0]            o_sat_cnt
`endif
);

  localparam int FRAME_W = 4 + OUT_W;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int DIV_W   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int GAP_W   = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SCLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CS_GAP - 1);
  localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(FRAME_W - 1);

  localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] SAT_MIN = IN_W'(-(1 << (OUT_W - 1)));

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  state_t                  state;
  logic [FRAME_W-1:0]      shreg;
  logic [BIT_W-1:0]        bit_idx;
  logic [DIV_W-1:0]        div_cnt;
  logic [GAP_W-1:0]        gap_cnt;

  logic signed [IN_W-1:0]  shifted;
  logic signed [OUT_W-1:0] clipped;
  logic                    sat_next;
  logic [FRAME_W-1:0]      word_next;

  // Scale, clip and convert the incoming sample to the frame word
  always_comb begin
    shifted  = i_sample >>> SHIFT;
    clipped  = shifted[OUT_W-1:0];
    sat_next = 1'b0;
    if (shifted > SAT_MAX) begin
      clipped  = SAT_MAX[OUT_W-1:0];
      sat_next = 1'b1;
    end else if (shifted < SAT_MIN) begin
      clipped  = SAT_MIN[OUT_W-1:0];
      sat_next = 1'b1;
    end
    word_next = {CMD, ~clipped[OUT_W-1], clipped[OUT_W-2:0]};
  end

  // Frame sequencer: accept, shift out MSB first, then hold CS_N high
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      div_cnt <= '0;
      gap_cnt <= '0;
      o_ready <= 1'b1;
      o_sat   <= 1'b0;
      o_cs_n  <= 1'b1;
      o_sclk  <= 1'b0;
      o_mosi  <= 1'b0;
    end else begin
      o_sat <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid && o_ready) begin
            state   <= XFER;
            shreg   <= word_next;
            bit_idx <= BIT_LOAD;
            div_cnt <= DIV_LOAD;
            o_ready <= 1'b0;
            o_sat   <= sat_next;
            o_cs_n  <= 1'b0;
            o_sclk  <= 1'b0;
            o_mosi  <= word_next[FRAME_W-1];
          end
        end
        XFER: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
          end else if (!o_sclk) begin
            o_sclk  <= 1'b1;
            div_cnt <= DIV_LOAD;
          end else if (bit_idx == '0) begin
            state   <= GAP;
            o_sclk  <= 1'b0;
            o_cs_n  <= 1'b1;
            o_mosi  <= 1'b0;
            gap_cnt <= GAP_LOAD;
          end else begin
            // next bit is presented together with the falling SCLK edge
            bit_idx <= bit_idx - 1'b1;
            shreg   <= shreg << 1;
            o_mosi  <= shreg[FRAME_W-2];
            o_sclk  <= 1'b0;
            div_cnt <= DIV_LOAD;
          end
        end
        GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else begin
            state   <= IDLE;
            o_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DAC_SAT_COUNT_EN
  // Saturating count of clipped samples
  always_ff @(posedge clk) begin
    if (rst) begin
      o_sat_cnt <= '0;
    end else if (o_sat && (o_sat_cnt != 16'hFFFF)) begin
      o_sat_cnt <= o_sat_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dac_spi_tx.sv
// Testbench for dac_spi_tx: randomized samples, reference model queue,
// and an SPI-decoding monitor that pops and compares each frame.
module tb_dac_spi_tx;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [17:0] i_sample;
  logic               i_valid;
  logic               o_ready;
  logic               o_sat;
  logic               o_cs_n;
  logic               o_sclk;
  logic               o_mosi;
`ifdef DAC_SAT_COUNT_EN
  logic [15:0]        o_sat_cnt;
`endif

  dac_spi_tx dut (
    .clk      (clk),
    .rst      (rst),
    .i_sample (i_sample),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .o_sat    (o_sat),
    .o_cs_n   (o_cs_n),
    .o_sclk   (o_sclk),
    .o_mosi   (o_mosi)
`ifdef DAC_SAT_COUNT_EN
    ,
    .o_sat_cnt(o_sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    logic        sat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   exp_satcnt = 0;
  logic rst_d = 1'b1;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= rst;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: floor-divide by 32, clip to 12-bit signed, add 2048, prefix 0x3.
  function automatic exp_t model(input logic signed [17:0] s);
    exp_t e;
    int v, q, c;
    v = int'(s);
    q = (v >= 0) ? v / 32 : -((-v + 31) / 32);
    e.sat = 1'b0;
    c = q;
    if (q > 2047) begin
      c = 2047;
      e.sat = 1'b1;
    end else if (q < -2048) begin
      c = -2048;
      e.sat = 1'b1;
    end
    e.word = 16'(32'h3000 + c + 2048);
    return e;
  endfunction

  task automatic push(input logic signed [17:0] s);
    exp_t e;
    e = model(s);
    exp_q.push_back(e);
    if (e.sat) exp_satcnt++;
  endtask

  task automatic wait_ready();
    int g;
    g = 0;
    while (!o_ready && g < 500) begin
      @(posedge clk); #1;
      g++;
    end
    if (!o_ready) chk("ready_timeout", 32'(o_ready), 32'd1);
  endtask

  // Accept one sample and measure the cycles until o_ready returns.
  task automatic send(input logic signed [17:0] s);
    int k;
    wait_ready();
    i_valid  = 1'b1;
    i_sample = s;
    push(s);
    @(posedge clk); #1;
    i_valid  = 1'b0;
    i_sample = 18'($urandom);
    k = 1;
    while (!o_ready && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    chk("ready_latency", 32'(k), 32'd67);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_ready"}, 32'(o_ready), 32'd1);
    chk({nm, "_sat"},   32'(o_sat),   32'd0);
    chk({nm, "_cs_n"},  32'(o_cs_n),  32'd1);
    chk({nm, "_sclk"},  32'(o_sclk),  32'd0);
    chk({nm, "_mosi"},  32'(o_mosi),  32'd0);
  endtask

  // Monitor: decode SPI frames and compare them against the queue
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
  logic        in_frame = 1'b0, bad_idle = 1'b0, bad_mosi = 1'b0;
  logic [15:0] rx_word;
  int          nbits, flen;
  exp_t        cur;

  always @(negedge clk) begin
    if (rst_d) begin
      in_frame  = 1'b0;
      prev_cs   = 1'b1;
      prev_sclk = 1'b0;
      prev_mosi = 1'b0;
    end else begin
      if (prev_cs && !o_cs_n) begin
        nbits   = 0;
        flen    = 0;
        rx_word = '0;
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 32'd1, 32'd0);
          in_frame = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          in_frame = 1'b1;
          chk("sat_pulse", 32'(o_sat), 32'(cur.sat));
        end
      end else if (o_sat) begin
        chk("sat_stray", 32'(o_sat), 32'd0);
      end
      if (o_cs_n && (o_sclk || o_mosi)) bad_idle = 1'b1;
      if (!o_cs_n && in_frame) begin
        flen++;
        if (!prev_sclk && o_sclk) begin
          rx_word = {rx_word[14:0], o_mosi};
          nbits++;
        end
        if (prev_sclk && o_sclk && (o_mosi != prev_mosi)) bad_mosi = 1'b1;
      end
      if (!prev_cs && o_cs_n && in_frame) begin
        chk("frame_word", 32'(rx_word), 32'(cur.word));
        chk("frame_bits", 32'(nbits), 32'd16);
        chk("frame_len",  32'(flen),  32'd64);
        chk("mosi_stable_high", 32'(bad_mosi), 32'd0);
        in_frame = 1'b0;
      end
      prev_cs   = o_cs_n;
      prev_sclk = o_sclk;
      prev_mosi = o_mosi;
    end
  end

  int acc_cyc[4];
  int n_acc;

  initial begin
    rst      = 1'b1;
    i_valid  = 1'b0;
    i_sample = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    exp_satcnt = 0;

    // Directed boundary cases
    send(18'sd0);
    send(18'sd65535);
    send(18'sd65536);
    send(-18'sd65536);
    send(18'sh20000);

    // Random samples, half kept near the clip thresholds
    for (int i = 0; i < 16; i++) begin
      if (i[0]) send(18'($urandom));
      else      send(18'(int'($urandom_range(0, 160000)) - 80000));
    end

    // i_valid held high with a fresh sample every cycle
    wait_ready();
    i_valid = 1'b1;
    n_acc = 0;
    for (int c = 0; c < 140; c++) begin
      i_sample = 18'($urandom);
      if (o_ready) begin
        push(i_sample);
        if (n_acc < 4) acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    chk("held_accepts", 32'(n_acc), 32'd3);
    chk("held_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd67);
    chk("held_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd67);

    // Reset in the middle of a frame
    wait_ready();
    i_valid  = 1'b1;
    i_sample = 18'sh1FFFF;
    push(i_sample);
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("mid_reset");
    rst = 1'b0;
    exp_q.delete();
    exp_satcnt = 0;
    send(18'sh04000);

    // Reset together with i_valid drops the sample
    wait_ready();
    rst      = 1'b1;
    i_valid  = 1'b1;
    i_sample = 18'sd1000;
    @(posedge clk); #1;
    rst     = 1'b0;
    i_valid = 1'b0;
    exp_satcnt = 0;
    chk_reset_outputs("rst_valid");
    repeat (10) @(posedge clk);
    #1;
    chk("rst_valid_no_frame", 32'(o_cs_n), 32'd1);

    // A few more clipped and unclipped frames after the resets
    send(18'sd70000);
    send(18'sd100);
    send(-18'sd100000);

    wait_ready();
    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("sclk_mosi_idle", 32'(bad_idle), 32'd0);
`ifdef DAC_SAT_COUNT_EN
    chk("sat_cnt", 32'(o_sat_cnt), 32'(exp_satcnt));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("sat_cnt_reset", 32'(o_sat_cnt), 32'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dac_spi_tx.md
Name: dac_spi_tx

Overview:
Downstream stage of the multi-tone summer. It consumes the 18-bit signed 1.3.14 combined waveform sample (cos or sin sum) and applies a scale-and-saturate step to a 12-bit code. It converts the code to offset binary and serialises it as one 16-bit SPI frame to an external 12-bit DAC. A valid/ready handshake lets the upstream summer run at clk rate while the DAC is updated at frame rate.

Parameters:
- IN_W, 18, input sample width (signed, 1.3.14).
- OUT_W, 12, DAC code width. Frame width is FRAME_W = 4 + OUT_W.
- SHIFT, 5, arithmetic right shift applied before saturation. The default maps ±4.0 to ±2048.
- CMD, 4'b0011, 4-bit DAC command prefix, sent first in each frame.
- SCLK_DIV, 2, clk cycles per SCLK half-period. Must be ≥1.
- CS_GAP, 2, clk cycles CS_N is held high after a frame. Must be ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- i_sample  in  IN_W  signed sample, 1.3.14.
- i_valid  in  1  i_sample is valid.
- o_ready  out  1  block can accept a sample.
- o_sat  out  1  one-cycle pulse: the accepted sample was clipped.
- o_cs_n  out  1  SPI chip select, active low.
- o_sclk  out  1  SPI clock, mode 0 (idle low).
- o_mosi  out  1  SPI data, MSB first.

Behaviour:
- Reset values:
  - o_ready=1, o_sat=0, o_cs_n=1, o_sclk=0, o_mosi=0.
  - State IDLE, all counters 0.
- All outputs are registered.
- Accept rule: a sample is taken on any cycle with i_valid && o_ready. i_valid while o_ready=0 is ignored; there is no buffering.
- Arithmetic, done on the accept cycle and latched:
  - s = i_sample >>> SHIFT (sign-preserving).
  - If s > 2^(OUT_W-1)-1, clip to 2^(OUT_W-1)-1 and set sat.
  - If s < -2^(OUT_W-1), clip to -2^(OUT_W-1) and set sat.
  - code = clipped value with MSB inverted (offset binary; 0 maps to 0x800).
  - word = {CMD, code}.
- FSM states:
  - IDLE: o_ready=1, o_cs_n=1, o_sclk=0, o_mosi=0. On accept: latch word, go to XFER next cycle. o_sat=sat for exactly that next cycle.
  - XFER: o_ready=0, o_cs_n=0.
    - Bit index runs from FRAME_W-1 down to 0; o_mosi = word[index].
    - Each bit: o_sclk low for SCLK_DIV cycles, then high for SCLK_DIV cycles. MOSI changes only while SCLK is low; the DAC samples on the rising edge.
    - After the high phase of bit 0, go to GAP.
    - Duration: FRAME_W·2·SCLK_DIV cycles (64 at defaults).
  - GAP: o_cs_n=1, o_sclk=0, o_mosi=0, o_ready=0. Lasts CS_GAP cycles, then IDLE.
- Timing:
  - Accept at cycle t: CS_N falls at t+1 and rises at t+65; o_ready is 1 again at t+67 (defaults).
  - Maximum rate is one sample per 1+FRAME_W·2·SCLK_DIV+CS_GAP cycles.
- Reset mid-operation: on the cycle after rst is asserted, all outputs and state equal their reset values. The partial frame is aborted, not resumed.
- rst together with i_valid: reset wins and the sample is dropped.
- o_sclk never toggles while o_cs_n=1.

Optional Feature:
DAC_SAT_COUNT_EN.
- Defined: adds output port o_sat_cnt (out, 16 bits). It increments on each o_sat pulse, saturates at 0xFFFF, and is cleared by rst.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- i_sample=0, accept at t → CS_N low t+1..t+64; MOSI bit stream 0x3800 MSB first, sampled on 16 rising SCLK edges; o_sat=0; o_ready=1 at t+67.
- i_sample=+65535 → code 0xFFF, o_sat=0. Then i_sample=+65536 → code 0xFFF, o_sat pulse one cycle at t+1.
- i_sample=-65536 → code 0x000, o_sat=0. Then i_sample=-131072 → code 0x000, o_sat=1.
- i_valid held high with changing samples → accepts only at t and t+67. Samples presented in between are not sent; frame data matches the sample present at each accept cycle.
- rst pulsed at t+30 mid-frame → at t+31: o_cs_n=1, o_sclk=0, o_ready=1. A following sample 0x04000 (+1.0) produces a complete frame 0x3A00.
- With DAC_SAT_COUNT_EN defined: 5 frames, 3 out of range → o_sat_cnt=3. Then rst → 0.
